id_branch_unit: RTL and testbench

- ID-side counterpart of the fetch stage: receives fetched PC/Instruction, holds them in the IF/ID pipeline register, resolves ARM B/BL branches, and drives Freeze, Branch_Taken and Branch_Addres back to fetch.
- Stalls conditional branches while flags are still being produced in EX/MEM (bounded stall FSM).
- Flushes the wrong-path instruction on a taken branch.

---
 rtl/id_branch_unit.sv | 128 ++++++++++++
 tb/tb_id_branch_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/id_branch_unit.sv
// IF/ID pipeline register with ARM B/BL resolution, flag-hazard stall FSM and wrong-path flush.
// Optional feature macro: ID_BRANCH_STATS_EN adds Taken_Count / Stall_Count outputs.
module id_branch_unit #(
   parameter int unsigned SR_STALL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC_in,
   input  logic [31:0] Instruction_in,
   input  logic [3:0]  SR,
   input  logic        SR_Busy,
   input  logic        Hazard,
   output logic        Freeze,
   output logic        Branch_Taken,
   output logic [31:0] Branch_Addres,
   output logic [31:0] PC,
   output logic [31:0] Instruction,
`ifdef ID_BRANCH_STATS_EN
   output logic [31:0] Taken_Count,
   output logic [31:0] Stall_Count,
`endif
   output logic        Valid
);

   typedef enum logic [1:0] {RUN, STALL, EVAL} state_t;

   localparam logic [3:0] COND_AL    = 4'b1110;
   localparam logic [3:0] STALL_LOAD = 4'(SR_STALL_CYCLES - 1);

   state_t     state;
   logic [3:0] count;
   logic       is_br;
   logic       cond_pass;
   logic       stall_req;
   logic       stall_frz;
   logic       n_f, z_f, c_f, v_f;
   logic [31:0] offset;

   assign {n_f, z_f, c_f, v_f} = SR;

   assign is_br = Valid & (Instruction[27:25] == 3'b101);

   always_comb begin
      cond_pass = 1'b0;
      case (Instruction[31:28])
         4'b0000: cond_pass = z_f;
         4'b0001: cond_pass = !z_f;
         4'b0010: cond_pass = c_f;
         4'b0011: cond_pass = !c_f;
         4'b0100: cond_pass = n_f;
         4'b0101: cond_pass = !n_f;
         4'b0110: cond_pass = v_f;
         4'b0111: cond_pass = !v_f;
         4'b1000: cond_pass = c_f & !z_f;
         4'b1001: cond_pass = !c_f | z_f;
         4'b1010: cond_pass = (n_f == v_f);
         4'b1011: cond_pass = (n_f != v_f);
         4'b1100: cond_pass = !z_f & (n_f == v_f);
         4'b1101: cond_pass = z_f | (n_f != v_f);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // The detect cycle itself must freeze, otherwise the branch would be
   // overwritten in IF/ID before the stall takes hold; it counts as the first
   // of the SR_STALL_CYCLES frozen cycles.
   assign stall_req = (state == RUN) & is_br & (Instruction[31:28] != COND_AL) & SR_Busy;
   assign stall_frz = stall_req | (state == STALL);

   assign offset = {{6{Instruction[23]}}, Instruction[23:0], 2'b00};

   assign Freeze        = !reset & (Hazard | stall_frz);
   assign Branch_Taken  = !reset & is_br & cond_pass & !Hazard & !stall_frz;
   assign Branch_Addres = reset ? 32'd0 : (PC + 32'd4 + offset);

   always_ff @(posedge clk) begin
      if (reset) begin
         PC          <= 32'd0;
         Instruction <= 32'd0;
         Valid       <= 1'b0;
      end else if (Branch_Taken) begin
         PC          <= 32'd0;
         Instruction <= 32'd0;
         Valid       <= 1'b0;
      end else if (!Freeze) begin
         PC          <= PC_in;
         Instruction <= Instruction_in;
         Valid       <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         count <= 4'd0;
      end else begin
         case (state)
            RUN: begin
               if (stall_req) begin
                  state <= (SR_STALL_CYCLES == 1) ? EVAL : STALL;
                  count <= STALL_LOAD;
               end
            end
            STALL: begin
               count <= count - 4'd1;
               if (count == 4'd1) state <= EVAL;
            end
            // SR_Busy is not consulted here, so the same branch cannot re-stall.
            EVAL:    state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

`ifdef ID_BRANCH_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         Taken_Count <= 32'd0;
         Stall_Count <= 32'd0;
      end else begin
         if (Branch_Taken) Taken_Count <= Taken_Count + 32'd1;
         if (stall_frz)    Stall_Count <= Stall_Count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_branch_unit.sv
// Scoreboard bench for id_branch_unit: expected outputs are queued with each stimulus
// cycle and compared at the following falling edge.
module tb_id_branch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC_in, Instruction_in;
   logic [3:0]  SR;
   logic        SR_Busy, Hazard;
   logic        Freeze, Branch_Taken, Valid;
   logic [31:0] Branch_Addres, PC, Instruction;
`ifdef ID_BRANCH_STATS_EN
   logic [31:0] Taken_Count, Stall_Count;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic        frz;
      logic        tk;
      logic [31:0] addr;
      logic        chk_addr;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        vld;
   } exp_t;

   exp_t sb[$];

   id_branch_unit #(.SR_STALL_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .PC_in(PC_in), .Instruction_in(Instruction_in),
      .SR(SR), .SR_Busy(SR_Busy), .Hazard(Hazard), .Freeze(Freeze),
      .Branch_Taken(Branch_Taken), .Branch_Addres(Branch_Addres), .PC(PC),
      .Instruction(Instruction),
`ifdef ID_BRANCH_STATS_EN
      .Taken_Count(Taken_Count), .Stall_Count(Stall_Count),
`endif
      .Valid(Valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // One cycle: drive inputs, queue the expected outputs, compare at negedge.
   task automatic step(input string name, input logic [31:0] pc_i, input logic [31:0] ins_i,
                       input logic [3:0] sr_i, input logic busy, input logic haz,
                       input logic e_frz, input logic e_tk, input logic [31:0] e_addr,
                       input logic e_chk, input logic [31:0] e_pc, input logic [31:0] e_ins,
                       input logic e_vld);
      exp_t e;
      PC_in = pc_i; Instruction_in = ins_i; SR = sr_i; SR_Busy = busy; Hazard = haz;
      e.name = name; e.frz = e_frz; e.tk = e_tk; e.addr = e_addr; e.chk_addr = e_chk;
      e.pc = e_pc; e.ins = e_ins; e.vld = e_vld;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
         check({name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({e.name, "_freeze"}, 32'(Freeze), 32'(e.frz));
         check({e.name, "_taken"},  32'(Branch_Taken), 32'(e.tk));
         if (e.chk_addr) check({e.name, "_addr"}, Branch_Addres, e.addr);
         check({e.name, "_pc"},    PC, e.pc);
         check({e.name, "_ins"},   Instruction, e.ins);
         check({e.name, "_valid"}, 32'(Valid), 32'(e.vld));
      end
      @(posedge clk);
      #1;
   endtask

   localparam logic [3:0] Z1 = 4'b0100;

   initial begin
      reset = 1'b1; PC_in = 32'h1234; Instruction_in = 32'hE1A00000;
      SR = 4'hF; SR_Busy = 1'b1; Hazard = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         check($sformatf("rst%0d_pc", i), PC, 32'd0);
         check($sformatf("rst%0d_ins", i), Instruction, 32'd0);
         check($sformatf("rst%0d_valid", i), 32'(Valid), 32'd0);
         check($sformatf("rst%0d_freeze", i), 32'(Freeze), 32'd0);
         check($sformatf("rst%0d_taken", i), 32'(Branch_Taken), 32'd0);
         check($sformatf("rst%0d_addr", i), Branch_Addres, 32'd0);
      end
      reset = 1'b0; Hazard = 1'b0; SR_Busy = 1'b0; SR = 4'h0;
      @(posedge clk);
      #1;

      //    name      PC_in         Instr          SR   busy haz  frz  tk   addr          chk  PC            Instr          V
      step("capture", 32'h104,      32'hEA000010, 4'h0, 0,   0,   0,   0,   32'h0,        0,   32'h1234,     32'hE1A00000,  1);
      step("bal",     32'h108,      32'hE1A00001, 4'h0, 0,   0,   0,   1,   32'h148,      1,   32'h104,      32'hEA000010,  1);
      step("flush1",  32'h148,      32'hE1A00002, 4'h0, 0,   0,   0,   0,   32'h0,        0,   32'h0,        32'h0,         0);
      step("cap2",    32'h104,      32'hEAFFFFFE, 4'h0, 0,   0,   0,   0,   32'h0,        0,   32'h148,      32'hE1A00002,  1);
      step("back",    32'h108,      32'hE1A00003, 4'h0, 0,   0,   0,   1,   32'h100,      1,   32'h104,      32'hEAFFFFFE,  1);
      step("flush2",  32'hFFFFFFFC, 32'hEA000001, 4'h0, 0,   0,   0,   0,   32'h0,        0,   32'h0,        32'h0,         0);
      step("wrap",    32'h0,        32'hE1A00004, 4'h0, 0,   0,   0,   1,   32'h4,        1,   32'hFFFFFFFC, 32'hEA000001,  1);
      step("flush3",  32'h200,      32'h0A000003, 4'h0, 1,   0,   0,   0,   32'h0,        0,   32'h0,        32'h0,         0);
      step("beq_det", 32'h204,      32'hE1A00005, 4'h0, 1,   0,   1,   0,   32'h0,        0,   32'h200,      32'h0A000003,  1);
      step("beq_stl", 32'h204,      32'hE1A00005, Z1,   1,   0,   1,   0,   32'h0,        0,   32'h200,      32'h0A000003,  1);
      step("beq_evl", 32'h204,      32'hE1A00005, Z1,   1,   0,   0,   1,   32'h210,      1,   32'h200,      32'h0A000003,  1);
      step("flush4",  32'h210,      32'hE1A00006, Z1,   1,   0,   0,   0,   32'h0,        0,   32'h0,        32'h0,         0);
      step("cap3",    32'h300,      32'h1A000002, Z1,   0,   0,   0,   0,   32'h0,        0,   32'h210,      32'hE1A00006,  1);
      step("bne",     32'h304,      32'hE1A00007, Z1,   0,   0,   0,   0,   32'h0,        0,   32'h300,      32'h1A000002,  1);
      step("no_fl",   32'h400,      32'hEA000004, 4'h0, 0,   0,   0,   0,   32'h0,        0,   32'h304,      32'hE1A00007,  1);
      for (int i = 0; i < 3; i++)
         step($sformatf("haz%0d", i),
              32'h404,      32'hE1A00008, 4'h0, 0,   1,   1,   0,   32'h0,        0,   32'h400,      32'hEA000004,  1);
      step("haz_rel", 32'h404,      32'hE1A00008, 4'h0, 0,   0,   0,   1,   32'h414,      1,   32'h400,      32'hEA000004,  1);
      step("flush5",  32'h414,      32'hE1A00009, 4'h0, 0,   0,   0,   0,   32'h0,        0,   32'h0,        32'h0,         0);
      step("cap4",    32'h418,      32'hE1A0000A, 4'h0, 0,   0,   0,   0,   32'h0,        0,   32'h414,      32'hE1A00009,  1);

`ifdef ID_BRANCH_STATS_EN
      // Five redirects (bal, back, wrap, beq_evl, haz_rel) and two stall-frozen cycles.
      check("taken_count", Taken_Count, 32'd5);
      check("stall_count", Stall_Count, 32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
